// File: rtl/lfsr_pkg.sv
// Shared types and the 4-bit PRBS recurrence used by the checker (and later the generator).
package lfsr_pkg;

    localparam int unsigned LFSR_W = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // n3 = s2 ^ xnor(s1, s0); remaining bits shift down by one
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[2] ^ ~(s[1] ^ s[0]), s[3], s[2], s[1]};
    endfunction

endpackage

// File: rtl/lfsr_next_calc.sv
// Combinational one-step advance of the 4-bit PRBS recurrence.
module lfsr_next_calc
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] i_state,
    output logic [LFSR_W-1:0] o_next_c
);

    assign o_next_c = lfsr_next(i_state);

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises to the 4-bit LFSR stream, then flags/counts deviations.
// Optional stuck-word detector enabled by defining LFSR_CHK_STUCK_DET_EN.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned LOSS_THR = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LFSR_W-1:0]     din,
    input  logic                  din_valid,
    output logic                  locked,
    output logic                  err,
    output logic [CNT_W-1:0]      err_count,
`ifdef LFSR_CHK_STUCK_DET_EN
    output logic                  stuck,
`endif
    output logic [LFSR_W-1:0]     expected
);

    localparam int unsigned RUN_W = 4;

    state_t             r_state, w_state_nxt;
    logic [RUN_W-1:0]   r_match_cnt, w_match_nxt, w_match_inc;
    logic [RUN_W-1:0]   r_miss_cnt, w_miss_nxt, w_miss_inc;
    logic [LFSR_W-1:0]  r_expected, w_exp_nxt;
    logic               r_locked, w_locked_nxt;
    logic               r_err, w_err_nxt;
    logic [CNT_W-1:0]   r_err_count, w_cnt_nxt;
    logic [LFSR_W-1:0]  w_seed_next;
    logic [LFSR_W-1:0]  w_fly_next;
    logic               w_stuck_nxt;

    // Seed path follows din; flywheel path follows the local prediction
    lfsr_next_calc u_seed_next (.i_state(din),        .o_next_c(w_seed_next));
    lfsr_next_calc u_fly_next  (.i_state(r_expected), .o_next_c(w_fly_next));

    assign w_match_inc = r_match_cnt + RUN_W'(1);
    assign w_miss_inc  = r_miss_cnt + RUN_W'(1);

`ifdef LFSR_CHK_STUCK_DET_EN
    localparam int unsigned STUCK_RUN = 8;

    logic [LFSR_W-1:0]  r_last_din;
    logic [RUN_W-1:0]   r_run, w_run_nxt;
    logic               r_stuck;

    // Length of the current run of identical valid words, saturating at STUCK_RUN
    always_comb begin
        w_run_nxt   = r_run;
        w_stuck_nxt = r_stuck;
        if (din_valid) begin
            if ((r_run != RUN_W'(0)) && (din == r_last_din)) begin
                w_run_nxt = (r_run == RUN_W'(STUCK_RUN)) ? r_run : r_run + RUN_W'(1);
            end else begin
                w_run_nxt = RUN_W'(1);
            end
            w_stuck_nxt = (w_run_nxt == RUN_W'(STUCK_RUN));
        end
    end

    always_ff @(negedge clk) begin
        if (!reset) begin
            r_last_din <= '0;
            r_run      <= '0;
            r_stuck    <= 1'b0;
        end else begin
            if (din_valid) begin
                r_last_din <= din;
            end
            r_run   <= w_run_nxt;
            r_stuck <= w_stuck_nxt;
        end
    end

    assign stuck = r_stuck;
`else
    assign w_stuck_nxt = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_match_nxt  = r_match_cnt;
        w_miss_nxt   = r_miss_cnt;
        w_exp_nxt    = r_expected;
        w_locked_nxt = r_locked;
        w_err_nxt    = 1'b0;
        w_cnt_nxt    = r_err_count;

        if (din_valid) begin
            case (r_state)
                SEARCH: begin
                    w_exp_nxt   = w_seed_next;
                    w_match_nxt = '0;
                    w_state_nxt = VERIFY;
                end
                VERIFY: begin
                    w_exp_nxt = w_seed_next;
                    if (din == r_expected) begin
                        w_match_nxt = w_match_inc;
                        if (w_match_inc == RUN_W'(LOCK_CNT)) begin
                            w_state_nxt  = LOCKED;
                            w_locked_nxt = 1'b1;
                            w_miss_nxt   = '0;
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end
                LOCKED: begin
                    w_exp_nxt = w_fly_next;
                    if (din == r_expected) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_err_nxt  = 1'b1;
                        w_miss_nxt = w_miss_inc;
                        if (r_err_count != {CNT_W{1'b1}}) begin
                            w_cnt_nxt = r_err_count + CNT_W'(1);
                        end
                        if (w_miss_inc == RUN_W'(LOSS_THR)) begin
                            w_state_nxt  = SEARCH;
                            w_locked_nxt = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_nxt  = SEARCH;
                    w_locked_nxt = 1'b0;
                end
            endcase
        end

        // A stuck input means the pattern is not present at all
        if (w_stuck_nxt) begin
            w_state_nxt  = SEARCH;
            w_locked_nxt = 1'b0;
        end
    end

    always_ff @(negedge clk) begin
        if (!reset) begin
            r_state     <= SEARCH;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_expected  <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_expected  <= w_exp_nxt;
            r_locked    <= w_locked_nxt;
            r_err       <= w_err_nxt;
            r_err_count <= w_cnt_nxt;
        end
    end

    assign locked    = r_locked;
    assign err       = r_err;
    assign err_count = r_err_count;
    assign expected  = r_expected;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker (LOCK_CNT=3, LOSS_THR=2, CNT_W=2); stuck checks under LFSR_CHK_STUCK_DET_EN.
module tb_lfsr_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din;
    logic       din_valid;
    logic       locked;
    logic       err;
    logic [1:0] err_count;
    logic [3:0] expected;
`ifdef LFSR_CHK_STUCK_DET_EN
    logic       stuck;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lfsr_checker #(
        .LOCK_CNT (3),
        .LOSS_THR (2),
        .CNT_W    (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
`ifdef LFSR_CHK_STUCK_DET_EN
        .stuck     (stuck),
`endif
        .expected  (expected)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    // Present one word, let the falling edge sample it, then settle past the edge
    task automatic send(input logic v, input logic [3:0] d);
        din       = d;
        din_valid = v;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        din       = 4'b1111;
        din_valid = 1'b1;
        @(negedge clk);
        #1;
        reset     = 1'b1;
        din_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        din       = 4'b0000;
        din_valid = 1'b0;

        do_reset();
        chk("rst_locked",   4'(locked),    4'd0);
        chk("rst_err",      4'(err),       4'd0);
        chk("rst_errcnt",   4'(err_count), 4'd0);
        chk("rst_expected", expected,      4'b0000);

        // Acquire: seed plus three matching words
        send(1'b1, 4'b0000);
        chk("seed_locked", 4'(locked), 4'd0);
        chk("seed_exp",    expected,   4'b1000);
        send(1'b1, 4'b1000);
        chk("v1_locked",   4'(locked), 4'd0);
        send(1'b1, 4'b1100);
        chk("v2_locked",   4'(locked), 4'd0);
        chk("v2_err",      4'(err),    4'd0);
        send(1'b1, 4'b0110);
        chk("lock_locked", 4'(locked),    4'd1);
        chk("lock_err",    4'(err),       4'd0);
        chk("lock_cnt",    4'(err_count), 4'd0);
        chk("lock_exp",    expected,      4'b1011);

        // Single corrupt word: flywheel keeps predicting
        send(1'b1, 4'b0000);
        chk("bad1_err",    4'(err),       4'd1);
        chk("bad1_cnt",    4'(err_count), 4'd1);
        chk("bad1_locked", 4'(locked),    4'd1);
        chk("bad1_exp",    expected,      4'b1101);
        send(1'b1, 4'b1101);
        chk("fly_err",     4'(err),    4'd0);
        chk("fly_locked",  4'(locked), 4'd1);
        chk("fly_exp",     expected,   4'b1110);

        // Two consecutive corrupt words lose lock
        send(1'b1, 4'b0000);
        chk("bad2a_err",    4'(err),       4'd1);
        chk("bad2a_cnt",    4'(err_count), 4'd2);
        chk("bad2a_locked", 4'(locked),    4'd1);
        chk("bad2a_exp",    expected,      4'b1111);
        send(1'b1, 4'b0000);
        chk("bad2b_err",    4'(err),       4'd1);
        chk("bad2b_cnt",    4'(err_count), 4'd3);
        chk("bad2b_locked", 4'(locked),    4'd0);
        chk("bad2b_exp",    expected,      4'b0111);

        // Relock on a clean stream after LOCK_CNT+1 words
        send(1'b1, 4'b0111);
        chk("rl_seed_err",    4'(err),    4'd0);
        chk("rl_seed_locked", 4'(locked), 4'd0);
        chk("rl_seed_exp",    expected,   4'b0011);
        send(1'b1, 4'b0011);
        chk("rl1_locked",     4'(locked), 4'd0);
        send(1'b1, 4'b1001);
        chk("rl2_locked",     4'(locked), 4'd0);
        send(1'b1, 4'b0100);
        chk("rl3_locked",     4'(locked),    4'd1);
        chk("rl3_exp",        expected,      4'b0010);
        chk("rl3_cnt",        4'(err_count), 4'd3);

        // Valid gaps: prediction holds, no errors
        send(1'b0, 4'b1111);
        chk("gap1_exp",    expected,   4'b0010);
        chk("gap1_err",    4'(err),    4'd0);
        chk("gap1_locked", 4'(locked), 4'd1);
        send(1'b1, 4'b0010);
        chk("gap2_exp",    expected,   4'b0001);
        send(1'b0, 4'b0000);
        send(1'b0, 4'b0101);
        chk("gap3_exp",    expected,   4'b0001);
        chk("gap3_locked", 4'(locked), 4'd1);
        send(1'b1, 4'b0001);
        chk("gap4_exp",    expected,   4'b0000);
        chk("gap4_err",    4'(err),    4'd0);

        // Saturation, err not held across a gap, match clears miss count
        send(1'b1, 4'b1111);
        chk("sat_err",    4'(err),       4'd1);
        chk("sat_cnt",    4'(err_count), 4'd3);
        chk("sat_locked", 4'(locked),    4'd1);
        chk("sat_exp",    expected,      4'b1000);
        send(1'b0, 4'b1000);
        chk("hold_err",    4'(err),    4'd0);
        chk("hold_locked", 4'(locked), 4'd1);
        chk("hold_exp",    expected,   4'b1000);
        send(1'b1, 4'b1000);
        chk("clr_err",     4'(err),    4'd0);
        chk("clr_exp",     expected,   4'b1100);
        send(1'b1, 4'b0000);
        chk("miss1_err",    4'(err),    4'd1);
        chk("miss1_locked", 4'(locked), 4'd1);
        chk("miss1_exp",    expected,   4'b0110);
        send(1'b1, 4'b0110);
        chk("rec_err",     4'(err),    4'd0);
        chk("rec_exp",     expected,   4'b1011);

        // Reset while locked
        do_reset();
        chk("mrst_locked", 4'(locked),    4'd0);
        chk("mrst_cnt",    4'(err_count), 4'd0);
        chk("mrst_exp",    expected,      4'b0000);
        chk("mrst_err",    4'(err),       4'd0);

        // Mismatch in VERIFY reseeds without error
        send(1'b1, 4'b0000);
        send(1'b1, 4'b1111);
        chk("vrs_err",    4'(err),    4'd0);
        chk("vrs_locked", 4'(locked), 4'd0);
        chk("vrs_exp",    expected,   4'b0111);
        send(1'b1, 4'b0111);
        send(1'b1, 4'b0011);
        chk("vrs2_locked", 4'(locked), 4'd0);
        send(1'b1, 4'b1001);
        chk("vrs3_locked", 4'(locked),    4'd1);
        chk("vrs3_exp",    expected,      4'b0100);
        chk("vrs3_cnt",    4'(err_count), 4'd0);

`ifdef LFSR_CHK_STUCK_DET_EN
        // Continue the locked stream, then hold one word
        send(1'b1, 4'b0100);
        chk("stk_pre_locked", 4'(locked), 4'd1);
        for (int i = 0; i < 7; i++) begin
            send(1'b1, 4'b1100);
        end
        chk("stk7_stuck", 4'(stuck), 4'd0);
        send(1'b1, 4'b1100);
        chk("stk8_stuck",  4'(stuck),  4'd1);
        chk("stk8_locked", 4'(locked), 4'd0);
        send(1'b1, 4'b0110);
        chk("stk_clr",     4'(stuck),  4'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
